// File: rtl/seq_mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier: state encoding,
// default operand width and the iteration-counter width helper.
package seq_mult_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_RUN  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  localparam int DEF_WIDTH = 8;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_mult_ctrl.sv
// Sequencing FSM for seq_mult_unit: walks IDLE/LOAD/RUN/FIX/DONE, produces
// registered busy/done and decodes the current state for the datapath.
module seq_mult_ctrl
  import seq_mult_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_start,
  input  logic i_abort,
  input  logic i_last,
  output logic o_accept,
  output logic o_load,
  output logic o_run,
  output logic o_fix,
  output logic o_busy,
  output logic o_done
);

  state_t r_state;
  logic   r_busy;
  logic   r_done;

  // State register with busy/done registered alongside the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_state <= ST_LOAD;
            r_busy  <= 1'b1;
          end else begin
            r_busy <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (i_abort) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_state <= ST_RUN;
            r_busy  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (i_abort) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (i_last) begin
            r_state <= ST_FIX;
            r_busy  <= 1'b1;
          end else begin
            r_busy <= 1'b1;
          end
        end
        ST_FIX: begin
          r_busy <= 1'b0;
          if (i_abort) begin
            r_state <= ST_IDLE;
          end else begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_accept = (r_state == ST_IDLE) && i_start;
  assign o_load   = (r_state == ST_LOAD);
  assign o_run    = (r_state == ST_RUN);
  assign o_fix    = (r_state == ST_FIX);
  assign o_busy   = r_busy;
  assign o_done   = r_done;

endmodule

// File: rtl/seq_mult_unit.sv
// Sequential shift-add multiplier (signed or unsigned) with optional early
// termination; operand registers, accumulator, counter and sign fix-up live here.
module seq_mult_unit
  import seq_mult_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int EARLY_TERM = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic                 i_abort,
  input  logic                 i_is_signed,
  input  logic [WIDTH-1:0]     i_a,
  input  logic [WIDTH-1:0]     i_b,
  output logic [2*WIDTH-1:0]   o_result,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int CW = cnt_width(WIDTH);

  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_sgn;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_acc;
  logic [CW-1:0]      r_count;
  logic               r_neg;
  logic [2*WIDTH-1:0] r_result;

  logic               w_accept;
  logic               w_load;
  logic               w_run;
  logic               w_fix;
  logic               w_last;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH-1:0]   w_mplier_sh;

  // Magnitude of the most negative value wraps to itself, which is exactly
  // 2^(WIDTH-1) when read as unsigned.
  assign w_mag_a = (r_sgn && r_a[WIDTH-1]) ? (~r_a + WIDTH'(1)) : r_a;
  assign w_mag_b = (r_sgn && r_b[WIDTH-1]) ? (~r_b + WIDTH'(1)) : r_b;

  assign w_mplier_sh = {1'b0, r_mplier[WIDTH-1:1]};
  assign w_last      = (r_count == CW'(1)) ||
                       ((EARLY_TERM != 0) && (w_mplier_sh == '0));

  seq_mult_ctrl u_ctrl (
    .clk      (clk),
    .rst      (rst),
    .i_start  (i_start),
    .i_abort  (i_abort),
    .i_last   (w_last),
    .o_accept (w_accept),
    .o_load   (w_load),
    .o_run    (w_run),
    .o_fix    (w_fix),
    .o_busy   (o_busy),
    .o_done   (o_done)
  );

  // Operand capture, shift-add iteration and sign fix-up of the product.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_sgn    <= 1'b0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_count  <= '0;
      r_neg    <= 1'b0;
      r_result <= '0;
    end else begin
      if (w_accept) begin
        r_a   <= i_a;
        r_b   <= i_b;
        r_sgn <= i_is_signed;
      end
      if (w_load) begin
        r_mcand  <= {{WIDTH{1'b0}}, w_mag_a};
        r_mplier <= w_mag_b;
        r_neg    <= r_sgn & (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
        r_acc    <= '0;
        r_count  <= CW'(WIDTH);
      end else if (w_run) begin
        if (r_mplier[0]) begin
          r_acc <= r_acc + r_mcand;
        end
        r_mcand  <= r_mcand << 1;
        r_mplier <= w_mplier_sh;
        r_count  <= r_count - CW'(1);
      end
      // An abort during FIX must leave the previous result untouched.
      if (w_fix && !i_abort) begin
        r_result <= r_neg ? (-r_acc) : r_acc;
      end
    end
  end

  assign o_result = r_result;

endmodule

// File: tb/tb_seq_mult_unit.sv
// Scoreboard bench for seq_mult_unit: two instances (early termination on/off)
// fed identical stimulus, checked against an arithmetic reference model.
module tb_seq_mult_unit;

  localparam int W = 8;

  typedef struct {
    logic [2*W-1:0] res;
    int             cyc;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic           abort = 1'b0;
  logic           is_signed = 1'b0;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic [2*W-1:0] res_et, res_ne;
  logic           busy_et, busy_ne, done_et, done_ne;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t q_et[$];
  exp_t q_ne[$];
  exp_t e_et, e_ne;
  logic [W-1:0] edge_v [5] = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF};

  seq_mult_unit #(.WIDTH(W), .EARLY_TERM(1)) u_et (
    .clk(clk), .rst(rst), .i_start(start), .i_abort(abort), .i_is_signed(is_signed),
    .i_a(a), .i_b(b), .o_result(res_et), .o_busy(busy_et), .o_done(done_et)
  );

  seq_mult_unit #(.WIDTH(W), .EARLY_TERM(0)) u_ne (
    .clk(clk), .rst(rst), .i_start(start), .i_abort(abort), .i_is_signed(is_signed),
    .i_a(a), .i_b(b), .o_result(res_ne), .o_busy(busy_ne), .o_done(done_ne)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference product: exact integer product reduced mod 2^(2W).
  function automatic logic [2*W-1:0] model_prod(input logic [W-1:0] x, input logic [W-1:0] y,
                                                 input logic s);
    longint p;
    if (s) p = longint'($signed(x)) * longint'($signed(y));
    else   p = longint'(x) * longint'(y);
    return p[2*W-1:0];
  endfunction

  // RUN iterations: all W bits, or just enough to consume the multiplier magnitude.
  function automatic int run_cycles(input logic [W-1:0] y, input logic s, input bit et);
    int m;
    int k;
    if (!et) return W;
    m = (s && y[W-1]) ? (256 - int'(y)) : int'(y);
    k = 0;
    while (m > 0) begin
      k++;
      m = m >> 1;
    end
    return (k == 0) ? 1 : k;
  endfunction

  always @(negedge clk) begin
    if (!rst && done_et) begin
      if (q_et.size() == 0) begin
        check("et_unexpected_done", 1, 0);
      end else begin
        e_et = q_et.pop_front();
        check("et_result", res_et, e_et.res);
        check("et_done_cycle", cyc, e_et.cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && done_ne) begin
      if (q_ne.size() == 0) begin
        check("ne_unexpected_done", 1, 0);
      end else begin
        e_ne = q_ne.pop_front();
        check("ne_result", res_ne, e_ne.res);
        check("ne_done_cycle", cyc, e_ne.cyc);
      end
    end
  end

  task automatic go(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts,
                    input bit push, input bit ab, output int s);
    int guard = 0;
    @(posedge clk); #1;
    while ((busy_et || busy_ne || done_et || done_ne) && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 200) check("idle_timeout", guard, 0);
    a = ta; b = tb; is_signed = ts; start = 1'b1; abort = ab;
    s = cyc;
    if (push) begin
      q_et.push_back('{model_prod(ta, tb, ts), s + run_cycles(tb, ts, 1'b1) + 3});
      q_ne.push_back('{model_prod(ta, tb, ts), s + run_cycles(tb, ts, 1'b0) + 3});
    end
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    a = W'($urandom); b = W'($urandom); is_signed = 1'($urandom);
  endtask

  task automatic drain();
    int guard = 0;
    while ((q_et.size() != 0 || q_ne.size() != 0 || busy_et || busy_ne) && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    check("drain_timeout", guard >= 100, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int s;
    logic [W-1:0] ta, tb;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_result_et", res_et, 0);
    check("rst_result_ne", res_ne, 0);
    check("rst_busy_et", busy_et, 0);
    check("rst_busy_ne", busy_ne, 0);
    check("rst_done_et", done_et, 0);
    check("rst_done_ne", done_ne, 0);
    #1 rst = 1'b0;

    go(8'd13, 8'd11, 1'b0, 1'b1, 1'b0, s);
    for (int i = 1; i <= 11; i++) begin
      @(negedge clk);
      check("ne_busy_window", busy_ne, (i <= 10) ? 1 : 0);
    end
    drain();
    check("ne_13x11", res_ne, 16'd143);

    go(8'hFD, 8'h05, 1'b1, 1'b1, 1'b0, s);
    drain();
    check("signed_m3x5", res_et, 16'hFFF1);
    go(8'h80, 8'h80, 1'b1, 1'b1, 1'b0, s);
    drain();
    check("signed_min_sq", res_ne, 16'h4000);
    go(8'd255, 8'd1, 1'b0, 1'b1, 1'b0, s);
    drain();
    check("et_255x1", res_et, 16'd255);
    go(8'd255, 8'd0, 1'b0, 1'b1, 1'b0, s);
    drain();
    check("et_255x0", res_et, 16'd0);

    go(8'd13, 8'd11, 1'b0, 1'b1, 1'b0, s);
    drain();
    go(8'd200, 8'd100, 1'b0, 1'b0, 1'b0, s);
    while (cyc < s + 5) begin @(posedge clk); #1; end
    start = 1'b1; a = 8'd1; b = 8'd1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    check("abort_busy_et", busy_et, 0);
    check("abort_busy_ne", busy_ne, 0);
    check("abort_keep_et", res_et, 16'd143);
    check("abort_keep_ne", res_ne, 16'd143);
    repeat (15) @(posedge clk);
    #1;

    go(8'd200, 8'd100, 1'b0, 1'b0, 1'b0, s);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrun_rst_result", res_ne, 0);
    check("midrun_rst_busy", busy_et | busy_ne, 0);
    check("midrun_rst_done", done_et | done_ne, 0);
    go(8'd3, 8'd3, 1'b0, 1'b1, 1'b0, s);
    drain();
    check("after_rst_3x3", res_et, 16'd9);

    for (int n = 0; n < 40; n++) begin
      ta = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 4)] : W'($urandom);
      tb = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 4)] : W'($urandom);
      go(ta, tb, 1'($urandom), 1'b1, 1'($urandom), s);
    end
    drain();
    check("queue_et_empty", q_et.size(), 0);
    check("queue_ne_empty", q_ne.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
